// File: rtl/sd_stream_pkg.sv
// Shared types and song table for the SD block streaming scheduler.
package sd_stream_pkg;

  localparam int NUM_SONGS   = 4;
  localparam int BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DONE, THROTTLE, DRAIN, STOPPING, ERROR
  } sched_state_t;

  // Byte ranges of each song on the card; entry [0] is the rightmost word.
  localparam logic [NUM_SONGS-1:0][31:0] SONG_START = {
    32'd39_999_488, 32'd27_000_320, 32'd14_061_056, 32'd0
  };
  localparam logic [NUM_SONGS-1:0][31:0] SONG_END = {
    32'd52_000_256, 32'd39_999_488, 32'd27_000_320, 32'd14_060_960
  };

endpackage

// File: rtl/block_watchdog.sv
// Per-block watchdog: counts enabled cycles, pulses expired once at the limit.
module block_watchdog #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count while enabled; restart after expiry so the pulse is a single cycle.
  always_ff @(posedge clk_25mhz) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= expired ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/sd_stream_scheduler.sv
// Sequences SD block reads for one song into the audio FIFO, with FIFO
// throttling, a per-block watchdog and bounded retry of a stalled block.
module sd_stream_scheduler
  import sd_stream_pkg::*;
#(
  parameter int NUM_SONGS      = sd_stream_pkg::NUM_SONGS,
  parameter int BLOCK_BYTES    = sd_stream_pkg::BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int MAX_RETRY      = 3,
  parameter logic [NUM_SONGS-1:0][31:0] SONG_START_TBL = SONG_START,
  parameter logic [NUM_SONGS-1:0][31:0] SONG_END_TBL   = SONG_END,
  localparam int SEL_W = $clog2(NUM_SONGS),
  localparam int RTW   = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic [SEL_W-1:0] song_sel,
  input  logic             play,
  input  logic             stop,
  input  logic             sd_done,
  input  logic             fifo_prog_empty,
  input  logic             fifo_empty,
  output logic             sd_read,
  output logic [31:0]      sd_addr,
  output logic             fifo_ready,
  output logic             busy,
  output logic             error,
  output logic [23:0]      blocks_read
);

  sched_state_t   state, nxt;
  logic [31:0]    end_addr, addr_nxt, sel_start, sel_end;
  logic [RTW-1:0] retry;
  logic           wd_clr, wd_en, wd_exp;
  logic           load, adv, retry_inc;

  assign addr_nxt = sd_addr + 32'(BLOCK_BYTES);

  block_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .clr       (wd_clr),
    .en        (wd_en),
    .expired   (wd_exp)
  );

  // Song table lookup; out-of-range selections fall back to song 0.
  always_comb begin
    sel_start = SONG_START_TBL[0];
    sel_end   = SONG_END_TBL[0];
    if ({{(32-SEL_W){1'b0}}, song_sel} < 32'(NUM_SONGS)) begin
      sel_start = SONG_START_TBL[song_sel];
      sel_end   = SONG_END_TBL[song_sel];
    end
  end

  // State register.
  always_ff @(posedge clk_25mhz) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and per-cycle actions; sd_done beats expiry, stop beats both.
  always_comb begin
    nxt       = state;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    retry_inc = 1'b0;
    case (state)
      IDLE, ERROR: if (play && !stop) begin
        load = 1'b1;
        nxt  = (sel_start >= sel_end) ? IDLE : ISSUE;
      end
      ISSUE: begin
        wd_clr = 1'b1;
        nxt    = stop ? IDLE : WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_en = 1'b1;
        if (stop) nxt = sd_done ? IDLE : STOPPING;
        else if (sd_done) begin
          adv = 1'b1;
          nxt = (addr_nxt >= end_addr) ? DRAIN : THROTTLE;
        end else if (wd_exp) begin
          if (retry == RTW'(MAX_RETRY)) nxt = ERROR;
          else begin
            retry_inc = 1'b1;
            nxt       = ISSUE;
          end
        end
      end
      THROTTLE: begin
        if (stop)                 nxt = IDLE;
        else if (fifo_prog_empty) nxt = ISSUE;
      end
      DRAIN:    if (stop || fifo_empty) nxt = IDLE;
      STOPPING: begin
        wd_en = 1'b1;
        if (sd_done || wd_exp) nxt = IDLE;
      end
      default:  nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      sd_read     <= 1'b0;
      sd_addr     <= '0;
      end_addr    <= '0;
      fifo_ready  <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      blocks_read <= '0;
      retry       <= '0;
    end else begin
      sd_read <= (state == ISSUE) && !stop;
      busy    <= !(nxt == IDLE || nxt == ERROR);
      error   <= (nxt == ERROR);
      if (load) begin
        sd_addr     <= sel_start;
        end_addr    <= sel_end;
        blocks_read <= '0;
        retry       <= '0;
      end
      if (adv) begin
        sd_addr     <= addr_nxt;
        blocks_read <= blocks_read + 24'd1;
        retry       <= '0;
      end
      if (retry_inc) retry <= retry + RTW'(1);
      if (nxt == IDLE || nxt == ERROR) fifo_ready <= 1'b0;
      else if (adv)                    fifo_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Directed bench for sd_stream_scheduler with a transaction-level address model.
module tb_sd_stream_scheduler;

  localparam int T = 200;
  localparam logic [3:0][31:0] TB_START = {32'd10240, 32'd8192, 32'd4096, 32'd0};
  localparam logic [3:0][31:0] TB_END   = {32'd11264, 32'd8192, 32'd5120, 32'd1536};

  logic        clk_25mhz = 1'b0, rst = 1'b1;
  logic [1:0]  song_sel = '0;
  logic        play = 0, stop = 0, sd_done = 0, fifo_prog_empty = 1, fifo_empty = 0;
  logic        sd_read, fifo_ready, busy, error;
  logic [31:0] sd_addr;
  logic [23:0] blocks_read;

  int checks = 0, failures = 0, cyc = 0, rd_cnt = 0;
  logic [31:0] m_addr = '0;   // address the next read must target
  int          m_blocks = 0;  // blocks the DUT must report as completed
  logic        pend = 1'b0;   // a read is outstanding

  sd_stream_scheduler #(
    .TIMEOUT_CYCLES (T),
    .SONG_START_TBL (TB_START),
    .SONG_END_TBL   (TB_END)
  ) dut (
    .clk_25mhz (clk_25mhz), .rst (rst), .song_sel (song_sel), .play (play),
    .stop (stop), .sd_done (sd_done), .fifo_prog_empty (fifo_prog_empty),
    .fifo_empty (fifo_empty), .sd_read (sd_read), .sd_addr (sd_addr),
    .fifo_ready (fifo_ready), .busy (busy), .error (error), .blocks_read (blocks_read)
  );

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every read must target the modelled address with the modelled count, and
  // the address must hold until the block answers.
  always @(negedge clk_25mhz) begin
    if (rst || play) pend <= 1'b0;
    else if (sd_read) begin
      chk("rd_addr", sd_addr, m_addr);
      chk("rd_blocks", blocks_read, m_blocks);
      chk("rd_busy", busy, 1);
      pend   <= 1'b1;
      rd_cnt <= rd_cnt + 1;
    end else if (pend) begin
      if (sd_done)   pend <= 1'b0;
      else if (busy) chk("addr_hold", sd_addr, m_addr);
    end
    if (error) begin
      chk("err_busy", busy, 0);
      chk("err_ready", fifo_ready, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  task automatic do_play(input int s);
    song_sel = 2'(s); play = 1; m_addr = TB_START[s]; m_blocks = 0;
    step(1);
    play = 0;
  endtask

  task automatic wait_read(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (sd_read) begin at = cyc; break; end
      step(1);
    end
    if (at < 0) chk("read_seen", 0, 1);
  endtask

  // sd_done d cycles after now; returns with the cycle after the pulse.
  task automatic respond(input int d, input bit counted, output int done_at);
    step(d);
    sd_done = 1; done_at = cyc;
    step(1);
    sd_done = 0;
    if (counted) begin m_addr += 512; m_blocks++; end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_read"}, sd_read, 0);    chk({tag, "_addr"}, sd_addr, 0);
    chk({tag, "_ready"}, fifo_ready, 0); chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, error, 0);        chk({tag, "_blocks"}, blocks_read, 0);
  endtask

  initial begin
    int p, at, a1, a2, d, r0;
    step(3);
    chk_reset("rst");
    rst = 0;
    step(2);

    // Normal stream: three blocks 0/512/1024, then drain.
    p = cyc;
    do_play(0);
    chk("play_addr", sd_addr, 0);
    chk("play_busy", busy, 1);
    for (int b = 0; b < 3; b++) begin
      wait_read(10, at);
      if (b == 0) chk("play_to_read", at - p, 2);
      else        chk("done_to_read", at - d, 3);
      chk("blk_addr", sd_addr, 512 * b);
      respond(100, 1, d);
      chk("done_ready", fifo_ready, 1);
      chk("done_addr", sd_addr, 512 * (b + 1));
    end
    chk("drain_blocks", blocks_read, 3);
    r0 = rd_cnt;
    step(5);
    chk("drain_noread", rd_cnt, r0);
    chk("drain_busy", busy, 1);
    fifo_empty = 1;
    step(1);
    fifo_empty = 0;
    chk("drain_ready", fifo_ready, 0);
    chk("drain_idle", busy, 0);

    // Throttle: FIFO full after block 1 holds off the next read.
    do_play(0);
    wait_read(10, at);
    fifo_prog_empty = 0;
    respond(100, 1, d);
    r0 = rd_cnt;
    step(10000);
    chk("thr_noread", rd_cnt, r0);
    chk("thr_busy", busy, 1);
    chk("thr_err", error, 0);
    fifo_prog_empty = 1; p = cyc;
    wait_read(10, at);
    chk("thr_release", at - p, 2);
    chk("thr_addr", sd_addr, 512);
    respond(100, 1, d);
    wait_read(10, at);
    chk("thr_addr2", sd_addr, 1024);
    respond(100, 1, d);
    fifo_empty = 1; step(1); fifo_empty = 0;
    chk("thr_idle", busy, 0);

    // Timeout retry: two silent attempts, third answered.
    do_play(0);
    wait_read(10, a1);
    step(1);
    wait_read(T + 10, a2);
    chk("retry1_gap", a2 - a1, T + 1);
    chk("retry1_addr", sd_addr, 0);
    step(1);
    wait_read(T + 10, at);
    chk("retry2_gap", at - a2, T + 1);
    respond(100, 1, d);
    chk("retry_err", error, 0);
    chk("retry_blocks", blocks_read, 1);
    chk("retry_ready", fifo_ready, 1);
    stop = 1; step(1); stop = 0;   // stop while throttling
    chk("thr_stop_busy", busy, 0);
    chk("thr_stop_ready", fifo_ready, 0);

    // Error: four unanswered reads.
    r0 = rd_cnt;
    do_play(0);
    for (int i = 0; i < 4; i++) begin
      wait_read(T + 10, at);
      step(1);
    end
    step(T + 2);
    chk("err_reads", rd_cnt - r0, 4);
    chk("err_set", error, 1);
    chk("err_busy0", busy, 0);
    chk("err_ready0", fifo_ready, 0);
    do_play(1);
    chk("err_clear", error, 0);
    chk("err_replay_addr", sd_addr, 4096);

    // Stop in flight on song 1's second block.
    wait_read(10, at);
    respond(100, 1, d);
    wait_read(10, at);
    chk("stop_addr", sd_addr, 4608);
    step(20);
    stop = 1; step(1); stop = 0;
    chk("stopping_busy", busy, 1);
    step(49);
    sd_done = 1; step(1); sd_done = 0;
    chk("stop_idle", busy, 0);
    chk("stop_blocks", blocks_read, 1);
    chk("stop_ready", fifo_ready, 0);
    chk("stop_addr_held", sd_addr, 4608);

    // stop and sd_done together in WAIT_DONE: no advance, no count.
    do_play(3);
    wait_read(10, at);
    step(30);
    stop = 1; sd_done = 1; step(1); stop = 0; sd_done = 0;
    chk("stopdone_busy", busy, 0);
    chk("stopdone_blocks", blocks_read, 0);
    chk("stopdone_addr", sd_addr, 10240);

    // Empty song: start == end returns to idle with no read.
    r0 = rd_cnt;
    do_play(2);
    chk("empty_busy", busy, 0);
    chk("empty_addr", sd_addr, 8192);
    step(5);
    chk("empty_noread", rd_cnt, r0);

    // stop + play together from idle.
    song_sel = 1; play = 1; stop = 1; step(1); play = 0; stop = 0;
    chk("stopplay_busy", busy, 0);
    step(5);
    chk("stopplay_noread", rd_cnt, r0);

    // Reset in WAIT_DONE with a coincident sd_done, then a stray sd_done.
    do_play(3);
    wait_read(10, at);
    step(10);
    rst = 1; sd_done = 1; step(1);
    chk_reset("midrst");
    rst = 0; sd_done = 0;
    step(2);
    sd_done = 1; step(1); sd_done = 0; step(1);
    chk_reset("stray");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
